// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its neighbours: imem port, ALU/regfile feedback,
// and the decoded fields of the issued instruction.
interface fetch_unit_if #(
    parameter int ADDR_W = 12
);
    logic              stall;
    logic [ADDR_W-1:0] address_imem;
    logic [31:0]       q_imem;
    logic              is_ne;
    logic              is_lt;
    logic [31:0]       rd_data;
    logic              rstatus_nz;
    logic              instr_valid;
    logic [4:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        shamt;
    logic [4:0]        alu_op;
    logic [31:0]       imm32;
    logic [26:0]       target;
    logic [ADDR_W-1:0] issue_pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              redirect;

    modport master (
        input  stall, q_imem, is_ne, is_lt, rd_data, rstatus_nz,
        output address_imem, instr_valid, opcode, rd, rs, rt, shamt, alu_op,
               imm32, target, issue_pc, pc_plus1, redirect
    );

    modport slave (
        output stall, q_imem, is_ne, is_lt, rd_data, rstatus_nz,
        input  address_imem, instr_valid, opcode, rd, rs, rt, shamt, alu_op,
               imm32, target, issue_pc, pc_plus1, redirect
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch / next-PC stage: drives the synchronous imem, decodes the issued word and
// resolves control-flow redirects with a single squashed wrong-path slot.
module fetch_unit #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          resetn,
    fetch_unit_if.master  bus
);
    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_BEX = 5'b10110;

    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0] issue_pc_reg, issue_pc_next;
    logic              valid_reg, valid_next;

    logic [31:0]       instr;
    logic [31:0]       imm32_w;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] npc;
    logic              taken;
    logic              redirect_w;
    logic              unused_rd_bits;

    // A bubble decodes as all-zero, i.e. add r0,r0,r0.
    assign instr = valid_reg ? bus.q_imem : 32'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_imm
            if (gi < 17) begin : g_low
                assign imm32_w[gi] = instr[gi];
            end else begin : g_ext
                assign imm32_w[gi] = instr[16];
            end
        end
    endgenerate

    assign branch_pc      = issue_pc_reg + ADDR_W'(1) + imm32_w[ADDR_W-1:0];
    assign unused_rd_bits = ^bus.rd_data[31:ADDR_W];

    always_comb begin
        taken = 1'b0;
        npc   = instr[ADDR_W-1:0];
        case (instr[31:27])
            OP_J, OP_JAL: taken = 1'b1;
            OP_JR: begin
                taken = 1'b1;
                npc   = bus.rd_data[ADDR_W-1:0];
            end
            OP_BNE: begin
                taken = bus.is_ne;
                npc   = branch_pc;
            end
            OP_BLT: begin
                taken = bus.is_lt;
                npc   = branch_pc;
            end
            OP_BEX:  taken = bus.rstatus_nz;
            default: taken = 1'b0;
        endcase
    end

    assign redirect_w = valid_reg & taken;

    // Under stall everything holds, including a pending taken branch.
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        issue_pc_next = issue_pc_reg;
        valid_next    = valid_reg;
        if (!bus.stall) begin
            issue_pc_next = fetch_pc_reg;
            if (redirect_w) begin
                fetch_pc_next = npc;
                valid_next    = 1'b0;
            end else begin
                fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
                valid_next    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_reg <= RESET_PC;
            issue_pc_reg <= RESET_PC;
            valid_reg    <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            issue_pc_reg <= issue_pc_next;
            valid_reg    <= valid_next;
        end
    end

    // Re-reading the issued address while stalled keeps q_imem, and so every output, stable.
    assign bus.address_imem = bus.stall ? issue_pc_reg : fetch_pc_reg;

    assign bus.instr_valid = valid_reg;
    assign bus.opcode      = instr[31:27];
    assign bus.rd          = instr[26:22];
    assign bus.rs          = instr[21:17];
    assign bus.rt          = instr[16:12];
    assign bus.shamt       = instr[11:7];
    assign bus.alu_op      = instr[6:2];
    assign bus.imm32       = imm32_w;
    assign bus.target      = instr[26:0];
    assign bus.issue_pc    = issue_pc_reg;
    assign bus.pc_plus1    = issue_pc_reg + ADDR_W'(1);
    assign bus.redirect    = redirect_w;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for reset, then random
// programs checked against a slot-level model of the issue stream.
module tb_fetch_unit;
    logic clock = 1'b0;
    logic resetn = 1'b0;

    fetch_unit_if #(.ADDR_W(12)) bus ();

    fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:4095];
    always @(posedge clock) bus.q_imem <= mem[bus.address_imem];

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          st;
        bit          ne;
        bit          lt;
        bit          nz;
        logic [31:0] rdd;
        logic [11:0] pc;
        bit          v;
        bit          red;
        logic [11:0] addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit st, bit ne, bit lt, bit nz, logic [31:0] rdd,
                                logic [11:0] pc, bit v, bit red, logic [11:0] addr);
        vec_t r;
        r.st = st; r.ne = ne; r.lt = lt; r.nz = nz; r.rdd = rdd;
        r.pc = pc; r.v = v; r.red = red; r.addr = addr;
        return r;
    endfunction

    task automatic chk(string tag, string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s act=%h exp=%h", tag, name, act, exp);
        end
    endtask

    task automatic check_cycle(string tag, logic [11:0] e_pc, bit e_v, bit e_red,
                               logic [11:0] e_addr);
        logic [31:0] w;
        logic signed [16:0] imm;
        logic [11:0] p1;
        w   = e_v ? mem[e_pc] : 32'd0;
        imm = w[16:0];
        p1  = e_pc + 12'd1;
        $display("%s pc=%h v=%b red=%b addr=%h stall=%b word=%h",
                 tag, bus.issue_pc, bus.instr_valid, bus.redirect, bus.address_imem,
                 bus.stall, w);
        chk(tag, "instr_valid", 32'(bus.instr_valid), 32'(e_v));
        chk(tag, "issue_pc", 32'(bus.issue_pc), 32'(e_pc));
        chk(tag, "pc_plus1", 32'(bus.pc_plus1), 32'(p1));
        chk(tag, "redirect", 32'(bus.redirect), 32'(e_red));
        chk(tag, "address_imem", 32'(bus.address_imem), 32'(e_addr));
        chk(tag, "opcode", 32'(bus.opcode), 32'(w[31:27]));
        chk(tag, "rd", 32'(bus.rd), 32'(w[26:22]));
        chk(tag, "rs", 32'(bus.rs), 32'(w[21:17]));
        chk(tag, "rt", 32'(bus.rt), 32'(w[16:12]));
        chk(tag, "shamt", 32'(bus.shamt), 32'(w[11:7]));
        chk(tag, "alu_op", 32'(bus.alu_op), 32'(w[6:2]));
        chk(tag, "imm32", bus.imm32, 32'(imm));
        chk(tag, "target", 32'(bus.target), 32'(w[26:0]));
    endtask

    // Reference rules for control flow, straight from the opcode table.
    function automatic bit m_taken(logic [31:0] w, bit ne, bit lt, bit nz);
        case (w[31:27])
            5'd1, 5'd3, 5'd4: return 1'b1;
            5'd2:             return ne;
            5'd6:             return lt;
            5'd22:            return nz;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic int m_npc(int pc, logic [31:0] w, logic [31:0] rdd);
        logic signed [16:0] imm;
        imm = w[16:0];
        case (w[31:27])
            5'd2, 5'd6: return (pc + 1 + int'(imm)) & 'hFFF;
            5'd4:       return int'(rdd) & 'hFFF;
            default:    return int'(w[26:0]) & 'hFFF;
        endcase
    endfunction

    task automatic drive(bit st, bit ne, bit lt, bit nz, logic [31:0] rdd);
        bus.stall      = st;
        bus.is_ne      = ne;
        bus.is_lt      = lt;
        bus.rstatus_nz = nz;
        bus.rd_data    = rdd;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    function automatic logic [31:0] rtype(int i);
        logic [11:0] lo;
        lo = 12'(i);
        return {5'd0, 15'h2A5B, lo};
    endfunction

    initial begin
        // Directed program.
        for (int i = 0; i < 4096; i++) mem[i] = rtype(i);
        mem[12'h002] = {5'b00001, 27'h010};
        mem[12'h010] = {5'b00001, 27'h004};
        mem[12'h005] = {5'b00010, 5'd1, 5'd2, 17'h1FFFD};
        mem[12'h007] = {5'b00011, 27'h020};
        mem[12'h020] = {5'b00100, 5'd7, 22'd0};
        mem[12'h236] = {5'b00110, 5'd3, 5'd4, 17'd5};
        mem[12'h237] = {5'b00001, 27'h100};
        mem[12'h23C] = {5'b10110, 27'hFFE};

        //          st ne lt nz rdd          pc      v  red addr
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h000, 0, 0, 12'h000));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h000, 1, 0, 12'h001));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h001, 1, 0, 12'h002));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h002, 1, 1, 12'h003));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h003, 0, 0, 12'h010));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h010, 1, 1, 12'h011));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h011, 0, 0, 12'h004));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h004, 1, 0, 12'h005));
        tbl.push_back(mk(0, 1, 0, 0, 32'd0,      12'h005, 1, 1, 12'h006));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h006, 0, 0, 12'h003));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h003, 1, 0, 12'h004));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h004, 1, 0, 12'h005));
        tbl.push_back(mk(0, 0, 1, 1, 32'd0,      12'h005, 1, 0, 12'h006));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h006, 1, 0, 12'h007));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h007, 1, 1, 12'h008));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h008, 0, 0, 12'h020));
        tbl.push_back(mk(0, 0, 0, 0, 32'h1234,   12'h020, 1, 1, 12'h021));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h021, 0, 0, 12'h234));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h234, 1, 0, 12'h235));
        tbl.push_back(mk(1, 0, 0, 0, 32'd0,      12'h235, 1, 0, 12'h235));
        tbl.push_back(mk(1, 1, 1, 1, 32'd0,      12'h235, 1, 0, 12'h235));
        tbl.push_back(mk(1, 0, 0, 0, 32'd0,      12'h235, 1, 0, 12'h235));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h235, 1, 0, 12'h236));
        tbl.push_back(mk(1, 0, 1, 0, 32'd0,      12'h236, 1, 1, 12'h236));
        tbl.push_back(mk(1, 0, 1, 0, 32'd0,      12'h236, 1, 1, 12'h236));
        tbl.push_back(mk(0, 0, 1, 0, 32'd0,      12'h236, 1, 1, 12'h237));
        tbl.push_back(mk(0, 1, 1, 1, 32'd0,      12'h237, 0, 0, 12'h23C));
        tbl.push_back(mk(0, 0, 0, 1, 32'd0,      12'h23C, 1, 1, 12'h23D));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h23D, 0, 0, 12'hFFE));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'hFFE, 1, 0, 12'hFFF));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'hFFF, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 0, 0, 32'd0,      12'h000, 1, 0, 12'h001));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].ne, tbl[i].lt, tbl[i].nz, tbl[i].rdd);
            #1;
            check_cycle($sformatf("dir%0d", i), tbl[i].pc, tbl[i].v, tbl[i].red, tbl[i].addr);
            @(negedge clock);
        end

        // Async reset in the middle of a stalled taken branch: must act before any edge.
        do_reset();
        repeat (8) @(negedge clock);
        drive(1, 1, 1, 1, 32'hFFFF_FFFF);
        #2;
        resetn = 1'b0;
        #1;
        check_cycle("rst_mid", 12'h000, 0, 0, 12'h000);
        @(negedge clock);
        resetn = 1'b1;
        drive(0, 0, 0, 0, 32'd0);
        #1;
        check_cycle("rst_rel", 12'h000, 0, 0, 12'h000);
        @(negedge clock);

        // Random programs against the slot model.
        for (int i = 0; i < 4096; i++) begin
            logic [31:0] w;
            logic [4:0]  op;
            int          k;
            w = $urandom;
            if ($urandom_range(0, 9) < 6) begin
                op = 5'($urandom_range(0, 31));
                if (op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd22}) op = 5'd0;
            end else begin
                k = $urandom_range(0, 5);
                case (k)
                    0: op = 5'd1;
                    1: op = 5'd3;
                    2: op = 5'd4;
                    3: op = 5'd2;
                    4: op = 5'd6;
                    default: op = 5'd22;
                endcase
            end
            w[31:27] = op;
            mem[i] = w;
        end

        begin
            int          m_pc;
            bit          m_v;
            int          m_pend;
            bit          st, ne, lt, nz, tk;
            logic [31:0] rdd;
            int          e_addr;

            do_reset();
            m_pc = 0; m_v = 0; m_pend = 0;
            for (int c = 0; c < 400; c++) begin
                st  = ($urandom_range(0, 3) == 0);
                ne  = 1'($urandom);
                lt  = 1'($urandom);
                nz  = 1'($urandom);
                rdd = $urandom;
                drive(st, ne, lt, nz, rdd);
                #1;
                tk = m_v && m_taken(mem[m_pc], ne, lt, nz);
                e_addr = st ? m_pc : (m_v ? ((m_pc + 1) & 'hFFF) : m_pend);
                check_cycle($sformatf("rnd%0d", c), 12'(m_pc), m_v, tk, 12'(e_addr));
                if (c == 137 || c == 291) begin
                    #2;
                    resetn = 1'b0;
                    #1;
                    check_cycle($sformatf("rnd_rst%0d", c), 12'h000, 0, 0, 12'h000);
                    @(negedge clock);
                    resetn = 1'b1;
                    m_pc = 0; m_v = 0; m_pend = 0;
                end else begin
                    if (!st) begin
                        if (m_v) begin
                            if (tk) m_pend = m_npc(m_pc, mem[m_pc], rdd);
                            m_pc = (m_pc + 1) & 'hFFF;
                            m_v  = !tk;
                        end else begin
                            m_pc = m_pend;
                            m_v  = 1'b1;
                        end
                    end
                    @(negedge clock);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
